vga_wbm_arb: RTL



---
 rtl/vga_wbm_arb_pkg.sv | 15 +
 rtl/vga_wbm_arb_tout.sv | 38 +++
 rtl/vga_wbm_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vga_wbm_arb_pkg.sv
// Shared types and constants for the VGA core's two-requester Wishbone master arbiter.
package vga_wbm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int TOUT_W_DEF = 8;

endpackage

// File: rtl/vga_wbm_arb_tout.sv
// Bus-cycle watchdog: counts un-terminated strobe cycles and pulses expire_o on the
// (2**TOUT_W-1)th one, restarting the count. Holds while en_i is low; clr_i has priority.
module vga_wbm_arb_tout
  import vga_wbm_arb_pkg::*;
#(
  parameter int TOUT_W = TOUT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TOUT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc  = cnt_q + 1'b1;
  // Fires in the cycle the count would reach all-ones, so an ack in that same cycle wins.
  assign expire_o = en_i & ~clr_i & (&cnt_inc);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_wbm_arb.sv
// Round-robin arbiter for the VGA core's shared Wishbone master bus; grants are held for a whole CYC.
// Optional VGA_WBM_ARB_URGENT_EN adds m0_urgent_i, letting a starving line fifo jump the round-robin order.
module vga_wbm_arb
  import vga_wbm_arb_pkg::*;
#(
  parameter int TOUT_W = TOUT_W_DEF
) (
  input  logic        wb_clk_i,
  input  logic        rst_nreset_i,
`ifdef VGA_WBM_ARB_URGENT_EN
  input  logic        m0_urgent_i,
`endif
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_cab_i,
  input  logic        m0_we_i,
  input  logic [29:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_cab_i,
  input  logic        m1_we_i,
  input  logic [29:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_cab_o,
  output logic        wb_we_o,
  output logic [29:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [1:0]  gnt_o,
  output logic        tout_o
);

  arb_state_e state_q;
  logic       last_q;
  logic       urg_q;
  logic       urgent;
  logic       pick0;
  logic       timeout;
  logic       own0, own1;

`ifdef VGA_WBM_ARB_URGENT_EN
  assign urgent = m0_urgent_i & m0_cyc_i;
`else
  assign urgent = 1'b0;
`endif

  // In IDLE m0 wins when alone, when m1 was the last owner, or when flagged urgent.
  assign pick0 = m0_cyc_i & (~m1_cyc_i | (last_q == REQ1) | urgent);

  always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
    if (!rst_nreset_i) begin
      state_q <= IDLE;
      last_q  <= REQ1;
      urg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick0) begin
            state_q <= OWN0;
            urg_q   <= urgent;
          end else if (m1_cyc_i) begin
            state_q <= OWN1;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            // An urgent grant is off the books: m1 keeps its turn.
            if (!urg_q) last_q <= REQ0;
            urg_q   <= 1'b0;
            state_q <= m1_cyc_i ? OWN1 : IDLE;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            last_q <= REQ1;
            if (m0_cyc_i) begin
              state_q <= OWN0;
              urg_q   <= urgent;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign own0  = (state_q == OWN0);
  assign own1  = (state_q == OWN1);
  assign gnt_o = {own1, own0};

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_cab_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_sel_o = '0;
    if (own0) begin
      wb_cyc_o = m0_cyc_i;
      wb_stb_o = m0_stb_i;
      wb_cab_o = m0_cab_i;
      wb_we_o  = m0_we_i;
      wb_adr_o = m0_adr_i;
      wb_sel_o = m0_sel_i;
    end else if (own1) begin
      wb_cyc_o = m1_cyc_i;
      wb_stb_o = m1_stb_i;
      wb_cab_o = m1_cab_i;
      wb_we_o  = m1_we_i;
      wb_adr_o = m1_adr_i;
      wb_sel_o = m1_sel_i;
    end
  end

  // Every grant is preceded by a cycle with wb_cyc_o low, which restarts the watchdog.
  vga_wbm_arb_tout #(
    .TOUT_W (TOUT_W)
  ) u_tout (
    .clk_i    (wb_clk_i),
    .rst_ni   (rst_nreset_i),
    .clr_i    (~wb_cyc_o | wb_ack_i | wb_err_i),
    .en_i     (wb_stb_o),
    .expire_o (timeout)
  );

  assign tout_o   = timeout;
  assign m0_ack_o = own0 & wb_ack_i;
  assign m1_ack_o = own1 & wb_ack_i;
  assign m0_err_o = own0 & (wb_err_i | timeout);
  assign m1_err_o = own1 & (wb_err_i | timeout);

endmodule
